uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 73 +++++++
 rtl/uart_tx_buffer.sv | 104 ++++++++++
 tb/tb_uart_tx_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit buffer.
package uart_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned DEFAULT_DEPTH  = 16;
   localparam int unsigned DEFAULT_ADDR_W = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;

   // Rising-edge detect between the current and previous sample of a level.
   function automatic logic rise(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Byte FIFO: storage, wrapping pointers and an occupancy counter.
// A push against a full FIFO is dropped even if a pop happens on the same edge.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push_ok;
   logic              pop_ok;
   logic [CNT_W-1:0]  count_next;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Head entry is always visible so the consumer can latch it on the pop edge.
   assign dout = mem[rd_ptr];

   // Occupancy after this edge; push and pop together leave it unchanged.
   always_comb begin
      count_next = count;
      unique case ({push_ok, pop_ok})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // Storage array; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, count and the derived full/empty flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         count <= count_next;
         full  <= (count_next == CNT_W'(DEPTH));
         empty <= (count_next == '0);
      end
   end

endmodule : sync_fifo

// File: rtl/uart_tx_buffer.sv
// Host-side byte queue in front of a uart_tx: pops one byte at a time,
// strobes tx_dv for one cycle and waits for a fresh tx_done rising edge.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic [BYTE_W-1:0] data_byte,
   output logic              tx_dv,
   input  logic              tx_done,
   output logic              busy
);

   tx_state_e         state;
   tx_state_e         state_next;
   logic              pop_c;
   logic              tx_done_d;
   logic [BYTE_W-1:0] fifo_dout;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .pop   (pop_c),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Next-state decode; the pop happens on the edge that leaves IDLE.
   always_comb begin
      state_next = state;
      pop_c      = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop_c      = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (rise(tx_done, tx_done_d)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Registered outputs derived from the upcoming state, plus tx_done history.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_dv     <= 1'b0;
         busy      <= 1'b0;
         data_byte <= '0;
         tx_done_d <= 1'b0;
      end else begin
         tx_dv     <= (state_next == ISSUE);
         busy      <= (state_next != IDLE);
         tx_done_d <= tx_done;
         if (pop_c) begin
            data_byte <= fifo_dout;
         end
      end
   end

   // Sticky drop indication for writes that hit a full queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_en && full) begin
         overflow <= 1'b1;
      end
   end

endmodule : uart_tx_buffer

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_buffer;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] data_byte;
   logic       tx_dv;
   logic       tx_done;
   logic       busy;

   logic auto_mode;
   logic man_done;
   logic auto_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign tx_done = auto_mode ? auto_done : man_done;

   uart_tx_buffer #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .data_byte (data_byte),
      .tx_dv     (tx_dv),
      .tx_done   (tx_done),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a queue of stored bytes and a transmit phase
   // (0 = idle, 1 = strobing, 2 = waiting for a fresh done edge).
   byte unsigned mq[$];
   bit           m_valid = 1'b0;
   int           m_phase = 0;
   logic [7:0]   m_byte  = 8'h00;
   bit           m_ovf   = 1'b0;
   bit           m_done_d = 1'b0;

   always @(posedge clk) begin
      if (rst === 1'b1) begin
         mq.delete();
         m_phase  = 0;
         m_byte   = 8'h00;
         m_ovf    = 1'b0;
         m_done_d = 1'b0;
         m_valid  = 1'b1;
      end else if (m_valid) begin
         bit was_full;
         was_full = (mq.size() == DEPTH);
         if (m_phase == 0 && mq.size() != 0) begin
            m_byte  = mq.pop_front();
            m_phase = 1;
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (m_phase == 2 && tx_done === 1'b1 && !m_done_d) begin
            m_phase = 0;
         end
         if (wr_en === 1'b1) begin
            if (was_full) m_ovf = 1'b1;
            else          mq.push_back(wr_data);
         end
         m_done_d = (tx_done === 1'b1);
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("count",     32'(count),     32'(mq.size()));
         chk("full",      32'(full),      32'(mq.size() == DEPTH));
         chk("empty",     32'(empty),     32'(mq.size() == 0));
         chk("overflow",  32'(overflow),  32'(m_ovf));
         chk("data_byte", 32'(data_byte), 32'(m_byte));
         chk("tx_dv",     32'(tx_dv),     32'(m_phase == 1));
         chk("busy",      32'(busy),      32'(m_phase != 0));
      end
   end

   // Random downstream done activity for the randomized phase.
   always @(posedge clk) begin
      #2;
      auto_done = ($urandom_range(0, 3) == 0);
   end

   initial begin
      rst       = 1'b1;
      wr_en     = 1'b0;
      wr_data   = 8'h00;
      auto_mode = 1'b0;
      man_done  = 1'b0;
      auto_done = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;

      // Reset values
      chk("rst count",     32'(count),     32'd0);
      chk("rst empty",     32'(empty),     32'd1);
      chk("rst full",      32'(full),      32'd0);
      chk("rst overflow",  32'(overflow),  32'd0);
      chk("rst data_byte", 32'(data_byte), 32'h00);
      chk("rst tx_dv",     32'(tx_dv),     32'd0);
      chk("rst busy",      32'(busy),      32'd0);

      // Single byte latency
      wr_en = 1'b1; wr_data = 8'hA9;
      cyc();
      wr_en = 1'b0;
      chk("single count E0", 32'(count), 32'd1);
      chk("single tx_dv E0", 32'(tx_dv), 32'd0);
      cyc();
      chk("single tx_dv E1", 32'(tx_dv),     32'd1);
      chk("single data E1",  32'(data_byte), 32'hA9);
      chk("single count E1", 32'(count),     32'd0);
      cyc();
      chk("single tx_dv E2", 32'(tx_dv), 32'd0);
      repeat (3) cyc();
      chk("single busy wait", 32'(busy), 32'd1);
      man_done = 1'b1;
      cyc();
      chk("single busy released", 32'(busy), 32'd0);
      cyc();
      man_done = 1'b0;
      cyc();

      // Stuck-high done: edge in IDLE, held through ISSUE and WAIT_DONE
      man_done = 1'b1;
      cyc();
      wr_en = 1'b1; wr_data = 8'h33;
      cyc();
      wr_en = 1'b0;
      cyc();
      chk("stuck tx_dv", 32'(tx_dv), 32'd1);
      repeat (4) cyc();
      chk("stuck busy held", 32'(busy), 32'd1);
      man_done = 1'b0;
      cyc();
      chk("stuck busy low", 32'(busy), 32'd1);
      man_done = 1'b1;
      cyc();
      chk("stuck released", 32'(busy), 32'd0);
      man_done = 1'b0;
      cyc();

      // Fill and overflow with done held low
      for (int i = 0; i < 18; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h40 + i);
         cyc();
         if (i == 16) begin
            chk("fill count",    32'(count),    32'd16);
            chk("fill full",     32'(full),     32'd1);
            chk("fill overflow", 32'(overflow), 32'd0);
         end
      end
      wr_en = 1'b0;
      chk("ovf overflow",  32'(overflow),  32'd1);
      chk("ovf count",     32'(count),     32'd16);
      chk("ovf data_byte", 32'(data_byte), 32'h40);
      man_done = 1'b1;
      cyc();
      cyc();
      chk("ovf next byte",  32'(data_byte), 32'h41);
      chk("ovf next tx_dv", 32'(tx_dv),     32'd1);
      chk("ovf next count", 32'(count),     32'd15);
      man_done = 1'b0;

      // Simultaneous push and pop at count 3
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst2 overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h10 + i);
         cyc();
      end
      wr_en = 1'b0;
      cyc();
      cyc();
      chk("sim pre count", 32'(count), 32'd3);
      man_done = 1'b1;
      cyc();
      chk("sim idle busy", 32'(busy), 32'd0);
      wr_en = 1'b1; wr_data = 8'h14;
      cyc();
      chk("sim count",  32'(count),     32'd3);
      chk("sim tx_dv",  32'(tx_dv),     32'd1);
      chk("sim data",   32'(data_byte), 32'h11);
      wr_data = 8'h15;
      cyc();
      wr_en = 1'b0;
      chk("midframe count", 32'(count), 32'd4);
      chk("midframe busy",  32'(busy),  32'd1);

      // Reset mid-frame, write during reset ignored
      rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
      cyc();
      rst = 1'b0; wr_en = 1'b0;
      chk("mfr count",     32'(count),     32'd0);
      chk("mfr empty",     32'(empty),     32'd1);
      chk("mfr full",      32'(full),      32'd0);
      chk("mfr overflow",  32'(overflow),  32'd0);
      chk("mfr data_byte", 32'(data_byte), 32'h00);
      chk("mfr tx_dv",     32'(tx_dv),     32'd0);
      chk("mfr busy",      32'(busy),      32'd0);
      man_done = 1'b0;
      cyc();
      man_done = 1'b1;
      cyc();
      chk("mfr late done tx_dv", 32'(tx_dv), 32'd0);
      chk("mfr late done busy",  32'(busy),  32'd0);
      cyc();
      man_done = 1'b0;
      wr_en = 1'b1; wr_data = 8'h5A;
      cyc();
      wr_en = 1'b0;
      cyc();
      chk("mfr new tx_dv", 32'(tx_dv),     32'd1);
      chk("mfr new data",  32'(data_byte), 32'h5A);

      // Randomized traffic with random done activity and rare resets
      auto_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         int p;
         int thr;
         p   = (i / 500) % 3;
         thr = (p == 0) ? 2 : ((p == 1) ? 6 : 10);
         rst     = ($urandom_range(0, 249) == 0);
         wr_en   = ($urandom_range(0, 9) < thr);
         wr_data = 8'($urandom);
         cyc();
      end
      rst   = 1'b0;
      wr_en = 1'b0;
      repeat (400) cyc();
      chk("drain count", 32'(count), 32'd0);
      chk("drain empty", 32'(empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_tx_buffer
